// File: rtl/cic_comb_decimator.sv
// CIC decimator back half: keeps every R-th integrator sample, runs it through
// N comb (differentiator) stages with differential delay M, then truncates the
// result to OW bits and presents it with a one-cycle valid strobe.
// All comb arithmetic wraps modulo 2^IW, so integrator overflow upstream cancels
// out here. Parameter limits: OW <= IW, R >= 2, 1 <= N <= 8, M in {1, 2}.
module cic_comb_decimator #(
   parameter int IW = 10,
   parameter int OW = 10,
   parameter int R  = 4,
   parameter int N  = 3,
   parameter int M  = 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_valid,
   input  logic signed [IW-1:0] i_data,
   output logic                 o_valid,
   output logic        [OW-1:0] o_data
);

   localparam int CW = (R > 1) ? $clog2(R) : 1;

   // Decimation counter and keep decision
   logic [CW-1:0]      r_cnt;
   logic               w_keep;

   // Decimation register and its strobe (stage 0 of the comb chain)
   logic [IW-1:0]      r_dec;
   logic               r_s0;

   // Chain taps: index 0 is the decimation register, index k is comb stage k
   logic [N:0][IW-1:0] w_y;
   logic [N:0]         w_s;

   // Output register
   logic               r_out_valid;
   logic [OW-1:0]      r_out_data;

   assign w_keep = i_valid && (r_cnt == '0);

   // Count valid input samples modulo R; gaps in i_valid simply hold the count
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt <= '0;
      end else if (i_valid) begin
         r_cnt <= (r_cnt == CW'(R - 1)) ? '0 : r_cnt + CW'(1);
      end
   end

   // Capture the kept sample and raise the strobe that starts the comb chain
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_dec <= '0;
         r_s0  <= 1'b0;
      end else begin
         r_s0 <= w_keep;
         if (w_keep) begin
            r_dec <= i_data;
         end
      end
   end

   assign w_y[0] = r_dec;
   assign w_s[0] = r_s0;

   // Comb stages: each one differences its input against the input it saw
   // M strobes earlier and passes a one-cycle strobe to the next stage.
   genvar gi;
   for (gi = 1; gi <= N; gi++) begin : g_stage
      logic [IW-1:0]         r_y;
      logic [M-1:0][IW-1:0]  r_d;
      logic                  r_s;

      // Difference and delay-line shift happen only on the upstream strobe
      always_ff @(posedge i_clk or negedge i_reset_n) begin
         if (!i_reset_n) begin
            r_y <= '0;
            r_d <= '0;
            r_s <= 1'b0;
         end else begin
            r_s <= w_s[gi-1];
            if (w_s[gi-1]) begin
               r_y    <= w_y[gi-1] - r_d[M-1];
               r_d[0] <= w_y[gi-1];
               for (int j = 1; j < M; j++) begin
                  r_d[j] <= r_d[j-1];
               end
            end
         end
      end

      assign w_y[gi] = r_y;
      assign w_s[gi] = r_s;
   end

   // Truncate the last comb result to the top OW bits and flag it for one cycle
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_out_valid <= w_s[N];
         if (w_s[N]) begin
            r_out_data <= w_y[N][IW-1 -: OW];
         end
      end
   end

   assign o_valid = r_out_valid;
   assign o_data  = r_out_data;

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Bench for cic_comb_decimator. Three instances share one input stream:
//   0: default (N=3, OW=10), 1: single comb stage (N=1), 2: truncated (OW=8).
// A reference model computes each expected output from the full history of
// kept samples (N-fold M-lag difference, wrapped to 10 bits, then shifted
// down to OW bits) and checks every cycle; a table of scenarios checks exact
// output sequences, latency and output spacing.
module tb_cic_comb_decimator;

   localparam int IW   = 10;
   localparam int R_P  = 4;
   localparam int M_P  = 1;
   localparam int ND   = 3;
   localparam int NROW = 6;

   logic          clk;
   logic          rst_n;
   logic          i_valid;
   logic [IW-1:0] i_data;
   logic          o_valid_a, o_valid_b, o_valid_c;
   logic [9:0]    o_data_a, o_data_b;
   logic [7:0]    o_data_c;

   cic_comb_decimator #(.IW(10), .OW(10), .R(R_P), .N(3), .M(M_P)) u_dut_a (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .i_data(i_data),
      .o_valid(o_valid_a), .o_data(o_data_a));

   cic_comb_decimator #(.IW(10), .OW(10), .R(R_P), .N(1), .M(M_P)) u_dut_b (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .i_data(i_data),
      .o_valid(o_valid_b), .o_data(o_data_b));

   cic_comb_decimator #(.IW(10), .OW(8), .R(R_P), .N(3), .M(M_P)) u_dut_c (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .i_data(i_data),
      .o_valid(o_valid_c), .o_data(o_data_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-instance configuration
   int cfg_n  [ND] = '{3, 1, 3};
   int cfg_ow [ND] = '{10, 10, 8};
   int lat_exp[ND] = '{4, 2, 4};

   typedef struct {
      int due;
      int val;
   } exp_t;

   typedef struct {
      int cyc;
      int val;
   } obs_t;

   typedef struct {
      int period;   // i_valid high once every 'period' cycles
      int mode;     // 0 constant, 1 ramp, 2 wrap pair
      int val;      // constant value for mode 0
      int gap;      // expected cycles between consecutive outputs
      int exp [12]; // first four outputs of instance 0, 1, 2
   } row_t;

   row_t rows [NROW];

   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   vcount = 0;
   int   hist[$];
   exp_t exp_q[ND][$];
   obs_t obs_q[ND][$];
   int   last_out[ND] = '{0, 0, 0};

   task automatic cmp(input string name, input int d, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s dut=%0d cyc=%0d actual=%0d required=%0d", name, d, cyc, act, req);
      end
   endtask

   // Output of an n-stage comb chain for the newest kept sample, from scratch
   function automatic int model_out(input int n, input int ow);
      int tmp[$];
      int v;
      tmp = hist;
      for (int s = 0; s < n; s++) begin
         for (int i = tmp.size() - 1; i >= M_P; i--) begin
            tmp[i] = tmp[i] - tmp[i-M_P];
         end
      end
      v = tmp[tmp.size()-1] & ((1 << IW) - 1);
      if (v >= (1 << (IW - 1))) v = v - (1 << IW);
      return v >>> (IW - ow);
   endfunction

   // Called at each falling edge: check outputs, then model the inputs that
   // the next rising edge will capture.
   task automatic check_and_model();
      int ov [ND];
      int od [ND];
      cyc++;
      ov[0] = int'(o_valid_a); od[0] = int'($signed(o_data_a));
      ov[1] = int'(o_valid_b); od[1] = int'($signed(o_data_b));
      ov[2] = int'(o_valid_c); od[2] = int'($signed(o_data_c));
      if (!rst_n) begin
         for (int d = 0; d < ND; d++) begin
            cmp("reset_valid", d, ov[d], 0);
            cmp("reset_data", d, od[d], 0);
            exp_q[d].delete();
            last_out[d] = 0;
         end
         hist.delete();
         vcount = 0;
      end else begin
         for (int d = 0; d < ND; d++) begin
            if (exp_q[d].size() > 0 && exp_q[d][0].due == cyc) begin
               cmp("model_valid", d, ov[d], 1);
               cmp("model_data", d, od[d], exp_q[d][0].val);
               last_out[d] = exp_q[d][0].val;
               void'(exp_q[d].pop_front());
            end else begin
               cmp("idle_valid", d, ov[d], 0);
               cmp("hold_data", d, od[d], last_out[d]);
            end
            if (ov[d] != 0) obs_q[d].push_back('{cyc, od[d]});
         end
         if (i_valid) begin
            if (vcount % R_P == 0) begin
               hist.push_back(int'($signed(i_data)));
               for (int d = 0; d < ND; d++) begin
                  exp_q[d].push_back('{cyc + cfg_n[d] + 2, model_out(cfg_n[d], cfg_ow[d])});
               end
            end
            vcount++;
         end
      end
   endtask

   // One clock: drive just after the rising edge, check at the falling edge
   task automatic cycle(input bit v, input int dat, input bit r);
      @(posedge clk);
      #1;
      if (!r && rst_n) begin
         rst_n = 1'b0;
         #1;
         cmp("rst_now_valid", 0, int'(o_valid_a), 0);
         cmp("rst_now_data", 0, int'($signed(o_data_a)), 0);
         cmp("rst_now_valid", 1, int'(o_valid_b), 0);
         cmp("rst_now_valid", 2, int'(o_valid_c), 0);
      end
      rst_n   = r;
      i_valid = v;
      i_data  = dat[IW-1:0];
      @(negedge clk);
      check_and_model();
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0);
      cycle(1'b0, 0, 1'b1);
   endtask

   function automatic int row_data(input int r, input int vi);
      case (rows[r].mode)
         1:       return vi;
         2:       return (vi == 0) ? 511 : ((vi == 4) ? -512 : 0);
         default: return rows[r].val;
      endcase
   endfunction

   task automatic run_row(input int r, input bit with_reset);
      int base [ND];
      int c_in;
      int vi;
      int ncyc;
      if (with_reset) do_reset();
      for (int d = 0; d < ND; d++) base[d] = obs_q[d].size();
      vi   = 0;
      c_in = 0;
      ncyc = 4 * R_P * rows[r].period + 8;
      for (int i = 0; i < ncyc; i++) begin
         if (i % rows[r].period == 0) begin
            cycle(1'b1, row_data(r, vi), 1'b1);
            vi++;
         end else begin
            cycle(1'b0, 0, 1'b1);
         end
         if (i == 0) c_in = cyc;
      end
      for (int d = 0; d < ND; d++) begin
         cmp("row_out_count", d, (obs_q[d].size() - base[d] >= 4) ? 1 : 0, 1);
         if (obs_q[d].size() - base[d] >= 4) begin
            for (int k = 0; k < 4; k++) begin
               cmp($sformatf("row%0d_out%0d", r, k), d, obs_q[d][base[d]+k].val, rows[r].exp[d*4+k]);
            end
            cmp($sformatf("row%0d_latency", r), d, obs_q[d][base[d]].cyc - c_in - 1, lat_exp[d]);
            cmp($sformatf("row%0d_gap", r), d,
                obs_q[d][base[d]+1].cyc - obs_q[d][base[d]].cyc, rows[r].gap);
         end
      end
      $display("row %0d: period=%0d mode=%0d val=%0d, running miscompares=%0d",
               r, rows[r].period, rows[r].mode, rows[r].val, n_bad);
   endtask

   initial begin
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;

      // {inputs, expected outputs of instance 0 (N=3), 1 (N=1), 2 (OW=8)}
      rows[0].period = 1; rows[0].mode = 0; rows[0].val = 5;   rows[0].gap = 4;
      rows[0].exp = '{5, -10, 5, 0,    5, 0, 0, 0,      1, -3, 1, 0};
      rows[1].period = 1; rows[1].mode = 1; rows[1].val = 0;   rows[1].gap = 4;
      rows[1].exp = '{0, 4, -4, 0,     0, 4, 4, 4,      0, 1, -1, 0};
      rows[2].period = 3; rows[2].mode = 0; rows[2].val = 7;   rows[2].gap = 12;
      rows[2].exp = '{7, -14, 7, 0,    7, 0, 0, 0,      1, -4, 1, 0};
      rows[3].period = 1; rows[3].mode = 0; rows[3].val = 64;  rows[3].gap = 4;
      rows[3].exp = '{64, -128, 64, 0, 64, 0, 0, 0,     16, -32, 16, 0};
      rows[4].period = 1; rows[4].mode = 2; rows[4].val = 0;   rows[4].gap = 4;
      rows[4].exp = '{511, 3, -3, 1,   511, 1, -512, 0, 127, 0, -1, 0};
      rows[5].period = 2; rows[5].mode = 0; rows[5].val = -3;  rows[5].gap = 8;
      rows[5].exp = '{-3, 6, -3, 0,    -3, 0, 0, 0,     -1, 1, -1, 0};

      // Reset state is checked by the per-cycle model during do_reset
      for (int r = 0; r < NROW; r++) run_row(r, 1'b1);

      // Reset two cycles after a keep: in-flight sample must vanish
      do_reset();
      cycle(1'b1, 5, 1'b1);
      cycle(1'b1, 5, 1'b1);
      cycle(1'b1, 5, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b0, 0, 1'b0);
      cycle(1'b0, 0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1);
      $display("mid-run reset released, repeating constant-5 scenario");
      run_row(0, 1'b0);

      // Random traffic with varying density and occasional resets
      do_reset();
      for (int blk = 0; blk < 8; blk++) begin
         int dens;
         dens = (blk % 3 == 0) ? 1 : ((blk % 3 == 1) ? 2 : 5);
         for (int i = 0; i < 100; i++) begin
            bit v;
            bit r;
            v = ($urandom_range(0, dens - 1) == 0);
            r = ($urandom_range(0, 249) != 0);
            cycle(v, int'($urandom_range(0, 1023)) - 512, r);
         end
         cycle(1'b0, 0, 1'b1);
         $display("random block %0d (density 1/%0d): running miscompares=%0d", blk, dens, n_bad);
      end
      for (int i = 0; i < 8; i++) cycle(1'b0, 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
